// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two issue-slot memory stages, the arbiter and the data memory.
// The arbiter takes the slave modport; the core/memory side takes master.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_addr, mem_wd, conflict_cnt
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_addr, mem_wd, conflict_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between two issue slots, one access per cycle.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise slot 0 always wins ties.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);

  logic              grant0;
  logic              grant1;
  logic              conflict;
  logic [ADDR_W-1:0] portAddr;
  logic [DATA_W-1:0] portWdata;
  logic              rvalid0Q;
  logic              rvalid1Q;
  logic [DATA_W-1:0] rdata0Q;
  logic [DATA_W-1:0] rdata1Q;
  logic [CNT_W-1:0]  conflictCntQ;

  assign conflict = bus.req0 && bus.req1;

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {PRI0, PRI1} priState_t;

  priState_t priState;
  priState_t priNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) priState <= PRI0;
    else       priState <= priNext;
  end

  // A tie goes to the favoured slot, and the favour then flips to the other one.
  always_comb begin
    priNext = priState;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (!reset) begin
      if (conflict) begin
        if (priState == PRI0) begin
          grant0  = 1'b1;
          priNext = PRI1;
        end else begin
          grant1  = 1'b1;
          priNext = PRI0;
        end
      end else begin
        grant0 = bus.req0;
        grant1 = bus.req1;
      end
    end
  end
`else
  // Slot 0 holds the older instruction, so it wins every tie to keep program order.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = bus.req0;
      grant1 = bus.req1 && !bus.req0;
    end
  end
`endif

  // With no grant the port idles on slot 0's inputs; only mem_we matters then.
  always_comb begin
    portAddr  = bus.addr0;
    portWdata = bus.wdata0;
    if (grant1) begin
      portAddr  = bus.addr1;
      portWdata = bus.wdata1;
    end
  end

  assign bus.gnt0     = grant0;
  assign bus.gnt1     = grant1;
  assign bus.mem_we   = (grant0 && bus.we0) || (grant1 && bus.we1);
  assign bus.mem_addr = portAddr;
  assign bus.mem_wd   = portWdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0Q <= 1'b0;
      rvalid1Q <= 1'b0;
      rdata0Q  <= '0;
      rdata1Q  <= '0;
    end else begin
      rvalid0Q <= grant0 && !bus.we0;
      rvalid1Q <= grant1 && !bus.we1;
      if (grant0 && !bus.we0) rdata0Q <= bus.mem_rd;
      if (grant1 && !bus.we1) rdata1Q <= bus.mem_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflictCntQ <= '0;
    end else if (conflict && (conflictCntQ != {CNT_W{1'b1}})) begin
      conflictCntQ <= conflictCntQ + CNT_W'(1);
    end
  end

  assign bus.rvalid0      = rvalid0Q;
  assign bus.rvalid1      = rvalid1Q;
  assign bus.rdata0       = rdata0Q;
  assign bus.rdata1       = rdata1Q;
  assign bus.conflict_cnt = conflictCntQ;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, directed corner sequences and
// randomized requesters checked against a transaction-level model of the arbiter.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic        r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  bus4 ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .bus(bus4));

  assign bus.req0 = r0;    assign bus.req1 = r1;
  assign bus.we0 = w0;     assign bus.we1 = w1;
  assign bus.addr0 = a0;   assign bus.addr1 = a1;
  assign bus.wdata0 = d0;  assign bus.wdata1 = d1;
  assign bus4.req0 = r0;   assign bus4.req1 = r1;
  assign bus4.we0 = w0;    assign bus4.we1 = w1;
  assign bus4.addr0 = a0;  assign bus4.addr1 = a1;
  assign bus4.wdata0 = d0; assign bus4.wdata1 = d1;

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  assign bus.mem_rd  = mem[bus.mem_addr[7:0]];
  assign bus4.mem_rd = mem[bus4.mem_addr[7:0]];

  function automatic logic [31:0] memPattern(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= memPattern(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wd;
    end
  end

  // Reference model state
  logic [31:0] refMem [256];
  bit          expRv0, expRv1, favour;
  logic [31:0] expRd0, expRd1;
  int          expCnt, expCnt4;
  int          checks = 0, errors = 0;
  logic        sampMemWe;
  logic [31:0] sampMemAddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    expRv0 = 0; expRv1 = 0; expRd0 = '0; expRd1 = '0;
    expCnt = 0; expCnt4 = 0; favour = 0;
  endtask

  task automatic applyStimulus(input logic rq0, input logic we0i, input logic [31:0] ad0,
                               input logic [31:0] wd0, input logic rq1, input logic we1i,
                               input logic [31:0] ad1, input logic [31:0] wd1);
    r0 = rq0; w0 = we0i; a0 = ad0; d0 = wd0;
    r1 = rq1; w1 = we1i; a1 = ad1; d1 = wd1;
  endtask

  // One clock cycle: checks combinational outputs mid-cycle, predicts and checks the edge.
  task automatic checkOutput(output bit g0, output bit g1);
    bit eG0, eG1, eWe;
    logic [31:0] eAddr, eWd;
    #3;
    eG0 = 0; eG1 = 0;
    if (r0 && r1) begin
      if (RR && favour) eG1 = 1; else eG0 = 1;
      if (RR) favour = !favour;
    end else begin
      eG0 = r0; eG1 = r1;
    end
    eWe   = (eG0 && w0) || (eG1 && w1);
    eAddr = eG1 ? a1 : a0;
    eWd   = eG1 ? d1 : d0;
    check("gnt0", bus.gnt0, eG0);
    check("gnt1", bus.gnt1, eG1);
    check("mem_we", bus.mem_we, eWe);
    check("mem_addr", bus.mem_addr, eAddr);
    check("mem_wd", bus.mem_wd, eWd);
    g0 = bus.gnt0; g1 = bus.gnt1;
    sampMemWe = bus.mem_we; sampMemAddr = bus.mem_addr;
    expRv0 = eG0 && !w0;
    expRv1 = eG1 && !w1;
    if (expRv0) expRd0 = refMem[a0[7:0]];
    if (expRv1) expRd1 = refMem[a1[7:0]];
    if (eWe) refMem[eAddr[7:0]] = eWd;
    if (r0 && r1) begin
      if (expCnt < 65535) expCnt++;
      if (expCnt4 < 15) expCnt4++;
    end
    @(posedge clk); #1;
    check("rvalid0", bus.rvalid0, expRv0);
    check("rvalid1", bus.rvalid1, expRv1);
    check("rdata0", bus.rdata0, expRd0);
    check("rdata1", bus.rdata1, expRd1);
    check("conflict_cnt", bus.conflict_cnt, 64'(expCnt));
    check("conflict_cnt4", bus4.conflict_cnt, 64'(expCnt4));
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    reset = 1'b1;
    #1;
    modelReset();
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_cnt", bus.conflict_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic rq0, we0; logic [31:0] ad0, wd0;
    logic rq1, we1; logic [31:0] ad1, wd1;
    logic eG0, eG1, eWe; logic [31:0] eAddr;
  } vec_t;

  vec_t vecs [6];
  bit   g0, g1, pend0, pend1;
  bit   expWin [4];

  initial begin
    vecs[0] = '{0, 0, 32'h40, 32'h0,    0, 0, 32'h44, 32'h0,    0, 0, 0, 32'h40};
    vecs[1] = '{1, 0, 32'h10, 32'h0,    0, 0, 32'h44, 32'h0,    1, 0, 0, 32'h10};
    vecs[2] = '{0, 0, 32'h44, 32'h0,    1, 1, 32'h30, 32'hCAFE, 0, 1, 1, 32'h30};
    vecs[3] = '{1, 1, 32'h34, 32'h1234, 0, 0, 32'h48, 32'h0,    1, 0, 1, 32'h34};
    vecs[4] = '{0, 0, 32'h4C, 32'h0,    1, 0, 32'h30, 32'h0,    0, 1, 0, 32'h30};
    vecs[5] = '{1, 0, 32'h34, 32'h0,    0, 0, 32'h50, 32'h0,    1, 0, 0, 32'h34};
    expWin = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    for (int i = 0; i < 256; i++) refMem[i] = memPattern(i);

    doReset();
    preload = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rq0, vecs[i].we0, vecs[i].ad0, vecs[i].wd0,
                    vecs[i].rq1, vecs[i].we1, vecs[i].ad1, vecs[i].wd1);
      checkOutput(g0, g1);
      check($sformatf("vec%0d_gnt0", i), g0, vecs[i].eG0);
      check($sformatf("vec%0d_gnt1", i), g1, vecs[i].eG1);
      check($sformatf("vec%0d_mem_we", i), sampMemWe, vecs[i].eWe);
      check($sformatf("vec%0d_mem_addr", i), sampMemAddr, vecs[i].eAddr);
    end

    // Single load
    applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
    checkOutput(g0, g1);
    check("single_gnt0", g0, 1);
    check("single_rvalid0", bus.rvalid0, 1);
    check("single_rdata0", bus.rdata0, 32'hDEADBEEF);
    check("single_rvalid1", bus.rvalid1, 0);

    // Reset lands between a load grant and its return edge
    applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
    #3;
    check("mid_gnt0", bus.gnt0, 1);
    reset = 1'b1;
    #1;
    check("mid_gnt0_rst", bus.gnt0, 0);
    check("mid_rvalid0", bus.rvalid0, 0);
    check("mid_rdata0", bus.rdata0, 0);
    check("mid_cnt", bus.conflict_cnt, 0);
    @(posedge clk); #1;
    check("mid_rvalid0_edge", bus.rvalid0, 0);
    modelReset();
    reset = 1'b0;
    applyStimulus(0, 0, '0, '0, 1, 1, 32'h50, 32'hA5A5);
    checkOutput(g0, g1);
    check("post_rst_gnt1", g1, 1);
    check("post_rst_mem_we", sampMemWe, 1);
    check("post_rst_mem_addr", sampMemAddr, 32'h50);

    // Store/load conflict on one address
    doReset();
    applyStimulus(1, 1, 32'h20, 32'h11, 1, 0, 32'h20, '0);
    checkOutput(g0, g1);
    check("conf_c0_gnt0", g0, 1);
    check("conf_c0_gnt1", g1, 0);
    applyStimulus(0, 0, 32'h20, 32'h11, 1, 0, 32'h20, '0);
    checkOutput(g0, g1);
    check("conf_c1_gnt1", g1, 1);
    check("conf_rvalid1", bus.rvalid1, 1);
    check("conf_rdata1", bus.rdata1, 32'h11);
    check("conf_cnt", bus.conflict_cnt, 1);

    // Back-to-back conflicts, then saturation of the narrow counter
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 32'(i * 4), '0, 1, 0, 32'(8 + i * 4), '0);
      checkOutput(g0, g1);
      if (i < 4) begin
        check($sformatf("rr%0d_gnt1", i), g1, expWin[i]);
        check($sformatf("rr%0d_gnt0", i), g0, !expWin[i]);
      end
      if (i == 3) check("rr_cnt4", bus.conflict_cnt, 4);
    end
    check("sat_cnt4", bus4.conflict_cnt, 15);
    check("sat_cnt16", bus.conflict_cnt, 20);

    // Idle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 32'h60, 32'h77, 0, 0, 32'h64, 32'h88);
      checkOutput(g0, g1);
    end
    check("idle_mem_we", sampMemWe, 0);
    check("idle_gnt", {g0, g1}, 0);
    check("idle_cnt", bus.conflict_cnt, 20);
    check("idle_rvalid", {bus.rvalid0, bus.rvalid1}, 0);

    // Random requesters, each request held until granted
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; w0 = 1'($urandom_range(0, 1));
        a0 = 32'($urandom_range(0, 15)) << 2; d0 = $urandom;
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1; w1 = 1'($urandom_range(0, 1));
        a1 = 32'($urandom_range(0, 15)) << 2; d1 = $urandom;
      end
      r0 = pend0; r1 = pend1;
      checkOutput(g0, g1);
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
